aq_vidu_vid_dep_chk: RTL and testbench

AQ_VIDU_VID_DEP_CHK -- requirements
Module: aq_vidu_vid_dep_chk

---
 rtl/aq_vidu_vid_dep_chk_pkg.sv | 41 ++++
 rtl/aq_vidu_vid_dep_chk_if.sv | 23 ++
 rtl/aq_vidu_vid_dep_chk_opchk.sv | 21 ++
 rtl/aq_vidu_vid_dep_chk.sv | 107 ++++++++++
 tb/tb_aq_vidu_vid_dep_chk.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aq_vidu_vid_dep_chk_pkg.sv
// rtl/aq_vidu_vid_dep_chk_pkg.sv - shared WBT field offsets, type codes, state encoding and helpers
package aq_vidu_vid_dep_chk_pkg;

  // Per-vreg write-back table entry layout: {cnt, type, vld}
  localparam int WB_VEC_VLD  = 0;
  localparam int WB_VEC_TYPE = 1;
  localparam int WB_VEC_CNT  = 2;

  localparam int VREG_NUM = 32;
  localparam int ENTRY_W  = 3;
  localparam int WBT_W    = VREG_NUM * ENTRY_W;

  // Producer unit type
  localparam logic WB_VEC_TYPE_VFPU = 1'b0;
  localparam logic WB_VEC_TYPE_VLSU = 1'b1;

  typedef enum logic {
    DEP_EMPTY = 1'b0,
    DEP_HOLD  = 1'b1
  } dep_state_e;

  // Instruction fields captured on accept
  typedef struct packed {
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [4:0] vs3;
    logic [4:0] vd;
    logic [3:0] src_vld;   // {vd, vs3, vs2, vs1}
    logic       dstv_type;
  } dep_inst_t;

  function automatic logic [ENTRY_W-1:0] wbt_entry(input logic [WBT_W-1:0] data,
                                                   input logic [4:0] idx);
    return data[int'(idx)*ENTRY_W +: ENTRY_W];
  endfunction

  function automatic logic [VREG_NUM-1:0] vreg_onehot(input logic [4:0] idx);
    return {{(VREG_NUM-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/aq_vidu_vid_dep_chk_if.sv
// rtl/aq_vidu_vid_dep_chk_if.sv - IDU-to-dependency-check vector instruction handshake
interface aq_vidu_vid_dep_chk_if;
  logic       idu_dep_inst_vld;
  logic       idu_dep_inst_rdy;
  logic [4:0] idu_dep_vs1;
  logic [4:0] idu_dep_vs2;
  logic [4:0] idu_dep_vs3;
  logic [4:0] idu_dep_vd;
  logic [3:0] idu_dep_src_vld;
  logic       idu_dep_dstv_type;

  modport master (
    output idu_dep_inst_vld, idu_dep_vs1, idu_dep_vs2, idu_dep_vs3, idu_dep_vd,
           idu_dep_src_vld, idu_dep_dstv_type,
    input  idu_dep_inst_rdy
  );

  modport slave (
    input  idu_dep_inst_vld, idu_dep_vs1, idu_dep_vs2, idu_dep_vs3, idu_dep_vd,
           idu_dep_src_vld, idu_dep_dstv_type,
    output idu_dep_inst_rdy
  );
endinterface

// File: rtl/aq_vidu_vid_dep_chk_opchk.sv
// rtl/aq_vidu_vid_dep_chk_opchk.sv - single operand readiness check against one WBT entry
module aq_vidu_vid_dep_opchk
  import aq_vidu_vid_dep_chk_pkg::*;
(
  input  logic [ENTRY_W-1:0] entry,
  input  logic               is_dst,
  input  logic               need_type,
  output logic               ready
);

  // Sources wait for valid data; a VLSU destination may also overwrite a
  // VLSU-owned vreg once that entry has no outstanding writes
  always_comb begin
    ready = entry[WB_VEC_VLD];
    if (is_dst && (need_type == WB_VEC_TYPE_VLSU) &&
        (entry[WB_VEC_TYPE] == WB_VEC_TYPE_VLSU) && !entry[WB_VEC_CNT]) begin
      ready = 1'b1;
    end
  end

endmodule

// File: rtl/aq_vidu_vid_dep_chk.sv
// rtl/aq_vidu_vid_dep_chk.sv - one-entry vector dependency check stage; stall counter under VIDU_DEP_STALL_CNT_EN
module aq_vidu_vid_dep_chk
  import aq_vidu_vid_dep_chk_pkg::*;
(
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  aq_vidu_vid_dep_chk_if.slave idu,
  input  logic [WBT_W-1:0]     wbt_dep_read_data,
  output logic                 dep_is_inst_vld,
  input  logic                 is_dep_inst_rdy,
  output logic [VREG_NUM-1:0]  dep_wbt_create_en,
  output logic                 dep_wbt_dstv_type,
  input  logic                 rtu_vidu_flush_wbt,
  input  logic                 rtu_yy_xx_async_flush,
  output logic [15:0]          dep_stall_cnt,
  input  logic                 hpcp_dep_cnt_clr
);

  dep_state_e state;
  dep_inst_t  held;
  dep_inst_t  incoming;

  logic            flush;
  logic            fire;
  logic            accept;
  logic            inst_rdy;
  logic            all_rdy;
  logic [3:0]      op_rdy;
  logic [3:0][4:0] op_idx;

  assign op_idx = {held.vd, held.vs3, held.vs2, held.vs1};

  // Operand checks: index 0..2 are sources vs1/vs2/vs3, index 3 is vd
  for (genvar i = 0; i < 4; i++) begin : g_opchk
    aq_vidu_vid_dep_opchk u_opchk (
      .entry     (wbt_entry(wbt_dep_read_data, op_idx[i])),
      .is_dst    (i == 3),
      .need_type (held.dstv_type),
      .ready     (op_rdy[i])
    );
  end

  // Unused operands count as ready
  always_comb begin
    flush   = rtu_vidu_flush_wbt | rtu_yy_xx_async_flush;
    all_rdy = &(~held.src_vld | op_rdy);
  end

  assign dep_is_inst_vld = (state == DEP_HOLD) && all_rdy && !flush;
  assign fire            = dep_is_inst_vld && is_dep_inst_rdy;

  // A firing entry frees the register in the same cycle, so a new inst can
  // be taken without a bubble; reset and flush block acceptance
  assign inst_rdy             = !cpurst && !flush && ((state == DEP_EMPTY) || fire);
  assign idu.idu_dep_inst_rdy = inst_rdy;
  assign accept               = idu.idu_dep_inst_vld && inst_rdy;

  assign incoming = '{vs1:       idu.idu_dep_vs1,
                      vs2:       idu.idu_dep_vs2,
                      vs3:       idu.idu_dep_vs3,
                      vd:        idu.idu_dep_vd,
                      src_vld:   idu.idu_dep_src_vld,
                      dstv_type: idu.idu_dep_dstv_type};

  assign dep_wbt_create_en = (fire && held.src_vld[3]) ? vreg_onehot(held.vd) : '0;
  assign dep_wbt_dstv_type = (state == DEP_HOLD) ? held.dstv_type : 1'b0;

  // Holding register and EMPTY/HOLD state; flush drops the held inst
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state <= DEP_EMPTY;
      held  <= '0;
    end else if (flush) begin
      state <= DEP_EMPTY;
      held  <= '0;
    end else if (accept) begin
      state <= DEP_HOLD;
      held  <= incoming;
    end else if (fire) begin
      state <= DEP_EMPTY;
      held  <= '0;
    end
  end

`ifdef VIDU_DEP_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Count held cycles blocked by dependencies; clear wins, saturate at max
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      stall_cnt_q <= '0;
    end else if (hpcp_dep_cnt_clr) begin
      stall_cnt_q <= '0;
    end else if ((state == DEP_HOLD) && !dep_is_inst_vld && !flush &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign dep_stall_cnt = stall_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = hpcp_dep_cnt_clr;
  assign dep_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_aq_vidu_vid_dep_chk.sv
// tb/tb_aq_vidu_vid_dep_chk.sv - directed scoreboard bench for aq_vidu_vid_dep_chk
module tb_aq_vidu_vid_dep_chk;

`ifdef VIDU_DEP_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        forever_cpuclk = 1'b0;
  logic        cpurst;
  logic [95:0] wbt_dep_read_data;
  logic        dep_is_inst_vld;
  logic        is_dep_inst_rdy;
  logic [31:0] dep_wbt_create_en;
  logic        dep_wbt_dstv_type;
  logic        rtu_vidu_flush_wbt;
  logic        rtu_yy_xx_async_flush;
  logic [15:0] dep_stall_cnt;
  logic        hpcp_dep_cnt_clr;

  int checks = 0;
  int errors = 0;
  int fire_cnt = 0;
  logic [32:0] sb[$];

  aq_vidu_vid_dep_chk_if u_if ();

  aq_vidu_vid_dep_chk dut (
    .forever_cpuclk        (forever_cpuclk),
    .cpurst                (cpurst),
    .idu                   (u_if),
    .wbt_dep_read_data     (wbt_dep_read_data),
    .dep_is_inst_vld       (dep_is_inst_vld),
    .is_dep_inst_rdy       (is_dep_inst_rdy),
    .dep_wbt_create_en     (dep_wbt_create_en),
    .dep_wbt_dstv_type     (dep_wbt_dstv_type),
    .rtu_vidu_flush_wbt    (rtu_vidu_flush_wbt),
    .rtu_yy_xx_async_flush (rtu_yy_xx_async_flush),
    .dep_stall_cnt         (dep_stall_cnt),
    .hpcp_dep_cnt_clr      (hpcp_dep_cnt_clr)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every issue pops the expected {create_en, type}
  always @(negedge forever_cpuclk) begin
    if (!cpurst) begin
      if (dep_is_inst_vld && is_dep_inst_rdy) begin
        fire_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_issue", 32'(sb.size()), 32'd1);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          chk("create_en", dep_wbt_create_en, e[32:1]);
          chk("issue_type", 32'(dep_wbt_dstv_type), 32'(e[0]));
        end
      end else begin
        chk("create_idle", dep_wbt_create_en, 32'h0);
      end
    end
  end

  task automatic set_entry(input int n, input logic cnt, input logic typ, input logic vld);
    wbt_dep_read_data[n*3 +: 3] = {cnt, typ, vld};
  endtask

  task automatic all_valid();
    for (int n = 0; n < 32; n++) set_entry(n, 1'b0, 1'b0, 1'b1);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3,
                      input logic [4:0] d, input logic [3:0] sv, input logic t,
                      input bit exp_fire, output int waits);
    u_if.idu_dep_inst_vld  = 1'b1;
    u_if.idu_dep_vs1       = s1;
    u_if.idu_dep_vs2       = s2;
    u_if.idu_dep_vs3       = s3;
    u_if.idu_dep_vd        = d;
    u_if.idu_dep_src_vld   = sv;
    u_if.idu_dep_dstv_type = t;
    if (exp_fire) sb.push_back({(sv[3] ? (32'h1 << d) : 32'h0), t});
    waits = 0;
    @(negedge forever_cpuclk);
    while (!u_if.idu_dep_inst_rdy && waits < 50) begin
      @(negedge forever_cpuclk);
      waits++;
    end
    chk("accept_rdy", 32'(u_if.idu_dep_inst_rdy), 32'd1);
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic cycle();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic clr_cnt();
    hpcp_dep_cnt_clr = 1'b1;
    cycle();
    hpcp_dep_cnt_clr = 1'b0;
  endtask

  initial begin
    int w;
    int base;
    cpurst = 1'b1;
    u_if.idu_dep_inst_vld = 1'b0;
    u_if.idu_dep_vs1 = '0; u_if.idu_dep_vs2 = '0; u_if.idu_dep_vs3 = '0; u_if.idu_dep_vd = '0;
    u_if.idu_dep_src_vld = '0; u_if.idu_dep_dstv_type = 1'b0;
    wbt_dep_read_data = '0;
    is_dep_inst_rdy = 1'b1;
    rtu_vidu_flush_wbt = 1'b0;
    rtu_yy_xx_async_flush = 1'b0;
    hpcp_dep_cnt_clr = 1'b0;
    all_valid();
    repeat (3) @(posedge forever_cpuclk);
    #1;
    cpurst = 1'b0;

    // Reset state
    @(negedge forever_cpuclk);
    chk("rst_inst_rdy", 32'(u_if.idu_dep_inst_rdy), 32'd1);
    chk("rst_issue_vld", 32'(dep_is_inst_vld), 32'd0);
    chk("rst_create", dep_wbt_create_en, 32'h0);
    chk("rst_type", 32'(dep_wbt_dstv_type), 32'd0);
    chk("rst_stall_cnt", 32'(dep_stall_cnt), 32'd0);
    cycle();

    // All ready: issue the cycle after accept, create bit 5
    send(5'd3, 5'd4, 5'd0, 5'd5, 4'b1011, 1'b0, 1'b1, w);
    u_if.idu_dep_inst_vld = 1'b0;
    @(negedge forever_cpuclk);
    chk("t1_issue_vld", 32'(dep_is_inst_vld), 32'd1);
    cycle();

    // vreg 4 busy for 3 cycles
    clr_cnt();
    set_entry(4, 1'b0, 1'b0, 1'b0);
    send(5'd3, 5'd4, 5'd0, 5'd5, 4'b1011, 1'b0, 1'b1, w);
    u_if.idu_dep_inst_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge forever_cpuclk);
      chk("t2_stall_vld", 32'(dep_is_inst_vld), 32'd0);
      cycle();
    end
    set_entry(4, 1'b0, 1'b0, 1'b1);
    @(negedge forever_cpuclk);
    chk("t2_issue_vld", 32'(dep_is_inst_vld), 32'd1);
    chk("t2_stall_cnt", 32'(dep_stall_cnt), CNT_EN ? 32'd3 : 32'd0);
    cycle();

    // VLSU vd over VLSU entry with cnt=0 issues even though vld=0
    set_entry(7, 1'b0, 1'b1, 1'b0);
    send(5'd0, 5'd0, 5'd0, 5'd7, 4'b1000, 1'b1, 1'b1, w);
    u_if.idu_dep_inst_vld = 1'b0;
    @(negedge forever_cpuclk);
    chk("t3_vlsu_issue", 32'(dep_is_inst_vld), 32'd1);
    cycle();

    // Same with cnt=1: stall until vld
    set_entry(7, 1'b1, 1'b1, 1'b0);
    send(5'd0, 5'd0, 5'd0, 5'd7, 4'b1000, 1'b1, 1'b1, w);
    u_if.idu_dep_inst_vld = 1'b0;
    @(negedge forever_cpuclk);
    chk("t4_stall0", 32'(dep_is_inst_vld), 32'd0);
    chk("t4_hold_type", 32'(dep_wbt_dstv_type), 32'd1);
    cycle();
    @(negedge forever_cpuclk);
    chk("t4_stall1", 32'(dep_is_inst_vld), 32'd0);
    cycle();
    set_entry(7, 1'b1, 1'b1, 1'b1);
    @(negedge forever_cpuclk);
    chk("t4_issue", 32'(dep_is_inst_vld), 32'd1);
    cycle();

    // VFPU vd over VLSU entry stalls; flush drops it
    set_entry(7, 1'b0, 1'b1, 1'b0);
    send(5'd0, 5'd0, 5'd0, 5'd7, 4'b1000, 1'b0, 1'b0, w);
    u_if.idu_dep_inst_vld = 1'b0;
    @(negedge forever_cpuclk);
    chk("t5_stall", 32'(dep_is_inst_vld), 32'd0);
    cycle();
    rtu_vidu_flush_wbt = 1'b1;
    @(negedge forever_cpuclk);
    chk("t5_flush_rdy", 32'(u_if.idu_dep_inst_rdy), 32'd0);
    chk("t5_flush_vld", 32'(dep_is_inst_vld), 32'd0);
    cycle();
    rtu_vidu_flush_wbt = 1'b0;
    set_entry(7, 1'b0, 1'b0, 1'b1);
    @(negedge forever_cpuclk);
    chk("t5_after_rdy", 32'(u_if.idu_dep_inst_rdy), 32'd1);
    chk("t5_after_vld", 32'(dep_is_inst_vld), 32'd0);
    cycle();

    // Async flush of a held VLSU inst: type drops to 0 once empty
    set_entry(8, 1'b1, 1'b1, 1'b0);
    send(5'd0, 5'd0, 5'd0, 5'd8, 4'b1000, 1'b1, 1'b0, w);
    u_if.idu_dep_inst_vld = 1'b0;
    @(negedge forever_cpuclk);
    chk("t6_hold_type", 32'(dep_wbt_dstv_type), 32'd1);
    cycle();
    rtu_yy_xx_async_flush = 1'b1;
    cycle();
    rtu_yy_xx_async_flush = 1'b0;
    @(negedge forever_cpuclk);
    chk("t6_empty_type", 32'(dep_wbt_dstv_type), 32'd0);
    chk("t6_empty_rdy", 32'(u_if.idu_dep_inst_rdy), 32'd1);
    cycle();

    // Downstream not ready: valid held stable, then issue
    is_dep_inst_rdy = 1'b0;
    send(5'd9, 5'd9, 5'd9, 5'd9, 4'b1111, 1'b0, 1'b1, w);
    u_if.idu_dep_inst_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge forever_cpuclk);
      chk("t7_vld_stable", 32'(dep_is_inst_vld), 32'd1);
      chk("t7_rdy_blocked", 32'(u_if.idu_dep_inst_rdy), 32'd0);
      cycle();
    end
    is_dep_inst_rdy = 1'b1;
    cycle();

    // No operands used: issues with no create
    send(5'd1, 5'd2, 5'd3, 5'd31, 4'b0000, 1'b0, 1'b1, w);
    u_if.idu_dep_inst_vld = 1'b0;
    cycle();

    // Back-to-back: one issue per cycle, no waits for rdy
    base = fire_cnt;
    for (int i = 0; i < 4; i++) begin
      send(5'(i), 5'(i + 1), 5'(i + 2), 5'(i + 10), 4'b1111, 1'(i % 2), 1'b1, w);
      chk("t8_b2b_wait", 32'(w), 32'd0);
    end
    u_if.idu_dep_inst_vld = 1'b0;
    cycle();
    chk("t8_b2b_issues", 32'(fire_cnt - base), 32'd4);

    // Reset mid-HOLD drops the inst
    set_entry(4, 1'b0, 1'b0, 1'b0);
    send(5'd4, 5'd0, 5'd0, 5'd5, 4'b1001, 1'b1, 1'b0, w);
    u_if.idu_dep_inst_vld = 1'b0;
    cpurst = 1'b1;
    cycle();
    cpurst = 1'b0;
    @(negedge forever_cpuclk);
    chk("t9_rst_rdy", 32'(u_if.idu_dep_inst_rdy), 32'd1);
    chk("t9_rst_vld", 32'(dep_is_inst_vld), 32'd0);
    chk("t9_rst_type", 32'(dep_wbt_dstv_type), 32'd0);
    cycle();

`ifdef VIDU_DEP_STALL_CNT_EN
    // Saturation, then clear during a stall
    send(5'd4, 5'd0, 5'd0, 5'd5, 4'b1001, 1'b0, 1'b0, w);
    u_if.idu_dep_inst_vld = 1'b0;
    repeat (65540) @(posedge forever_cpuclk);
    #1;
    @(negedge forever_cpuclk);
    chk("t10_sat", 32'(dep_stall_cnt), 32'hFFFF);
    cycle();
    @(negedge forever_cpuclk);
    chk("t10_sat_hold", 32'(dep_stall_cnt), 32'hFFFF);
    clr_cnt();
    @(negedge forever_cpuclk);
    chk("t10_clr", 32'(dep_stall_cnt), 32'd0);
    rtu_vidu_flush_wbt = 1'b1;
    cycle();
    rtu_vidu_flush_wbt = 1'b0;
`else
    // Clear is ignored and the counter stays 0 during a stall
    send(5'd4, 5'd0, 5'd0, 5'd5, 4'b1001, 1'b0, 1'b0, w);
    u_if.idu_dep_inst_vld = 1'b0;
    repeat (3) cycle();
    @(negedge forever_cpuclk);
    chk("t10_cnt_off", 32'(dep_stall_cnt), 32'd0);
    rtu_vidu_flush_wbt = 1'b1;
    cycle();
    rtu_vidu_flush_wbt = 1'b0;
`endif
    set_entry(4, 1'b0, 1'b0, 1'b1);
    repeat (2) cycle();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
